// File: rtl/mod_tick_sched.sv
`default_nettype none
// ============================================================================
// mod_tick_sched : single-clock enable-strobe scheduler (sample/half/symbol)
// Revision 1.0
// ============================================================================
module mod_tick_sched #(
  parameter int unsigned W         = 16,
  parameter int unsigned DIV_A_RST = 500,
  parameter int unsigned DIV_B_RST = 1000,
  parameter int unsigned DIV_C_RST = 31250
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         stop_i,
  input  logic         cfg_valid_i,
  output logic         cfg_ready_o,
  input  logic [1:0]   cfg_sel_i,
  input  logic [W-1:0] cfg_div_i,
  output logic         tick_a_o,
  output logic         tick_b_o,
  output logic         tick_c_o,
  output logic         running_o,
  output logic         cfg_pending_o
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_WAIT = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d, cnt_c_q, cnt_c_d;
  logic [W-1:0]   div_a_q, div_a_d, div_b_q, div_b_d, div_c_q, div_c_d;
  logic           pend_q, pend_d;
  logic [1:0]     psel_q, psel_d;
  logic [W-1:0]   pdiv_q, pdiv_d;

  logic           active, wrap_a, wrap_b, wrap_c, accept, apply;
  logic [W-1:0]   div_clamped;

  assign active      = (state_q != ST_IDLE);
  assign wrap_a      = (cnt_a_q == div_a_q - W'(1));
  assign wrap_b      = (cnt_b_q == div_b_q - W'(1));
  assign wrap_c      = (cnt_c_q == div_c_q - W'(1));
  assign accept      = cfg_valid_i & ~pend_q;
  // While running, a pending divisor only lands on a symbol boundary.
  assign apply       = pend_q & (~active | wrap_c);
  assign div_clamped = (cfg_div_i < W'(2)) ? W'(2) : cfg_div_i;

  assign tick_a_o      = active & wrap_a;
  assign tick_b_o      = active & wrap_b;
  assign tick_c_o      = active & wrap_c;
  assign running_o     = active;
  assign cfg_pending_o = pend_q;
  assign cfg_ready_o   = ~pend_q;

  always_comb begin
    state_d = state_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    cnt_c_d = cnt_c_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    div_c_d = div_c_q;
    pend_d  = pend_q;
    psel_d  = psel_q;
    pdiv_d  = pdiv_q;

    case (state_q)
      ST_IDLE:      if (start_i) state_d = ST_RUN;
      ST_RUN:       if (stop_i && !start_i) state_d = ST_STOP_WAIT;
      ST_STOP_WAIT: begin
        if (start_i)     state_d = ST_RUN;
        else if (wrap_c) state_d = ST_IDLE;
      end
      default:      state_d = ST_IDLE;
    endcase

    // Applying a config mid-run re-aligns all three strobes to a common origin.
    if (!active || state_d == ST_IDLE || apply) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
      cnt_c_d = '0;
    end else begin
      cnt_a_d = wrap_a ? '0 : cnt_a_q + W'(1);
      cnt_b_d = wrap_b ? '0 : cnt_b_q + W'(1);
      cnt_c_d = wrap_c ? '0 : cnt_c_q + W'(1);
    end

    if (apply) begin
      pend_d = 1'b0;
      case (psel_q)
        2'd0:    div_a_d = pdiv_q;
        2'd1:    div_b_d = pdiv_q;
        2'd2:    div_c_d = pdiv_q;
        default: ;
      endcase
    end else if (accept && cfg_sel_i != 2'd3) begin
      pend_d = 1'b1;
      psel_d = cfg_sel_i;
      pdiv_d = div_clamped;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      cnt_c_q <= '0;
      div_a_q <= W'(DIV_A_RST);
      div_b_q <= W'(DIV_B_RST);
      div_c_q <= W'(DIV_C_RST);
      pend_q  <= 1'b0;
      psel_q  <= '0;
      pdiv_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      cnt_c_q <= cnt_c_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      div_c_q <= div_c_d;
      pend_q  <= pend_d;
      psel_q  <= psel_d;
      pdiv_q  <= pdiv_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mod_tick_sched.sv
`default_nettype none
// ============================================================================
// tb_mod_tick_sched : self-checking bench for mod_tick_sched
// Revision 1.0
// ============================================================================
module tb_mod_tick_sched;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_i = 1'b0;
  logic         stop_i = 1'b0;
  logic         cfg_valid_i = 1'b0;
  logic [1:0]   cfg_sel_i = 2'd0;
  logic [W-1:0] cfg_div_i = '0;
  logic         cfg_ready_o, tick_a_o, tick_b_o, tick_c_o, running_o, cfg_pending_o;
  logic [5:0]   act;

  int n_cmp = 0;
  int n_bad = 0;

  always #10 clk = ~clk;

  mod_tick_sched #(.W(W), .DIV_A_RST(500), .DIV_B_RST(1000), .DIV_C_RST(31250)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_sel_i(cfg_sel_i),
    .cfg_div_i(cfg_div_i), .tick_a_o(tick_a_o), .tick_b_o(tick_b_o), .tick_c_o(tick_c_o),
    .running_o(running_o), .cfg_pending_o(cfg_pending_o)
  );

  assign act = {tick_a_o, tick_b_o, tick_c_o, running_o, cfg_pending_o, cfg_ready_o};

  // Reference: each strobe fires when (elapsed cycles since its origin) mod div == div-1.
  int cyc = 0;
  bit m_run = 0, m_stopw = 0, m_pend = 0;
  int m_div[3] = '{500, 1000, 31250};
  int m_org[3] = '{0, 0, 0};
  int m_psel = 0, m_pdiv = 2;
  bit m_tc, m_apply, m_was_run;

  function automatic bit m_tick(input int x);
    return m_run && (((cyc - m_org[x]) % m_div[x]) == m_div[x] - 1);
  endfunction

  function automatic logic [5:0] exp_vec();
    return {m_tick(0), m_tick(1), m_tick(2), m_run, m_pend, !m_pend};
  endfunction

  always @(posedge clk) begin
    m_tc = m_tick(2);
    if (!rst) begin
      m_run = 0; m_stopw = 0; m_pend = 0;
      m_div[0] = 500; m_div[1] = 1000; m_div[2] = 31250;
    end else begin
      m_was_run = m_run;
      m_apply   = m_pend && (!m_run || m_tc);
      if (!m_run) begin
        if (start_i) begin
          m_run = 1; m_stopw = 0;
          for (int x = 0; x < 3; x++) m_org[x] = cyc + 1;
        end
      end else if (m_stopw) begin
        if (start_i) m_stopw = 0;
        else if (m_tc) begin m_run = 0; m_stopw = 0; end
      end else if (stop_i && !start_i) begin
        m_stopw = 1;
      end
      if (m_apply) begin
        m_div[m_psel] = m_pdiv;
        m_pend = 0;
        if (m_was_run) for (int x = 0; x < 3; x++) m_org[x] = cyc + 1;
      end else if (cfg_valid_i && !m_pend && cfg_sel_i != 2'd3) begin
        m_pend = 1;
        m_psel = int'(cfg_sel_i);
        m_pdiv = (int'(cfg_div_i) < 2) ? 2 : int'(cfg_div_i);
      end
    end
    cyc++;
  end

  task automatic cfg_write(input int sel, input int div);
    cfg_valid_i = 1'b1;
    cfg_sel_i   = 2'(sel);
    cfg_div_i   = W'(div);
    @(negedge clk);
    cfg_valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Runs ncyc cycles from the current negedge, pulsing stop/start at given indices,
  // and returns observations (strobe positions, spacing errors, model disagreements).
  task automatic run_obs(input int ncyc, input int stop_at, input int start_at,
                         input int per_a, input int per_c,
                         output int first_a, output int first_b, output int first_c,
                         output int bad_sp, output int idle_at, output int post_ticks,
                         output int nbad, output int first_bad);
    int last_a, last_c;
    first_a = -1; first_b = -1; first_c = -1; bad_sp = 0; idle_at = -1;
    post_ticks = 0; nbad = 0; first_bad = -1; last_a = -1; last_c = -1;
    for (int k = 0; k < ncyc; k++) begin
      if (act !== exp_vec()) begin
        if (nbad == 0) first_bad = k;
        nbad++;
      end
      if (tick_a_o) begin
        if (first_a < 0) first_a = k;
        else if (k - last_a != per_a) bad_sp++;
        last_a = k;
      end
      if (tick_b_o && first_b < 0) first_b = k;
      if (tick_c_o) begin
        if (first_c < 0) first_c = k;
        else if (k - last_c != per_c) bad_sp++;
        last_c = k;
      end
      if (!running_o && idle_at < 0) idle_at = k;
      if (idle_at >= 0 && (tick_a_o || tick_b_o || tick_c_o)) post_ticks++;
      stop_i  = (k == stop_at);
      start_i = (k == start_at);
      @(negedge clk);
    end
    stop_i = 1'b0; start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b0; stop_i = 1'b0; cfg_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (act !== 6'b000001) begin
      n_bad++; $display("FAIL reset_values: got %b want %b", act, 6'b000001);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (act !== 6'b000001) begin
      n_bad++; $display("FAIL reset_release: got %b want %b", act, 6'b000001);
    end
  endtask

  task automatic test_defaults_stop();
    int fa, fb, fc, sp, ia, pt, nb, fbad;
    pulse_start();
    run_obs(31300, 10000, -1, 500, 31250, fa, fb, fc, sp, ia, pt, nb, fbad);
    n_cmp++;
    if (fa != 499)   begin n_bad++; $display("FAIL dflt_first_a: got %0d want 499", fa); end
    n_cmp++;
    if (fb != 999)   begin n_bad++; $display("FAIL dflt_first_b: got %0d want 999", fb); end
    n_cmp++;
    if (fc != 31249) begin n_bad++; $display("FAIL stop_tick_c: got %0d want 31249", fc); end
    n_cmp++;
    if (ia != 31250) begin n_bad++; $display("FAIL stop_idle_at: got %0d want 31250", ia); end
    n_cmp++;
    if (sp != 0 || pt != 0) begin
      n_bad++; $display("FAIL dflt_spacing: spacing_errs %0d post_idle_ticks %0d want 0/0", sp, pt);
    end
    n_cmp++;
    if (nb != 0) begin n_bad++; $display("FAIL dflt_model: %0d bad cycles (first %0d) want 0", nb, fbad); end
  endtask

  task automatic test_cfg_idle();
    int fa, fb, fc, sp, ia, pt, nb, fbad;
    cfg_valid_i = 1'b1; cfg_sel_i = 2'd0; cfg_div_i = W'(250);
    n_cmp++;
    if (cfg_ready_o !== 1'b1) begin n_bad++; $display("FAIL idle_ready_before: got %b want 1", cfg_ready_o); end
    @(negedge clk);
    cfg_valid_i = 1'b0;
    n_cmp++;
    if ({cfg_ready_o, cfg_pending_o} !== 2'b01) begin
      n_bad++; $display("FAIL idle_ready_low: got %b want 01", {cfg_ready_o, cfg_pending_o});
    end
    @(negedge clk);
    n_cmp++;
    if ({cfg_ready_o, cfg_pending_o} !== 2'b10) begin
      n_bad++; $display("FAIL idle_ready_back: got %b want 10", {cfg_ready_o, cfg_pending_o});
    end
    cfg_write(2, 1000);
    pulse_start();
    run_obs(2100, 1100, -1, 250, 1000, fa, fb, fc, sp, ia, pt, nb, fbad);
    n_cmp++;
    if (fa != 249 || sp != 0 || ia != 2000 || nb != 0) begin
      n_bad++;
      $display("FAIL idle_cfg_250: first_a %0d sp %0d idle %0d bad %0d want 249/0/2000/0", fa, sp, ia, nb);
    end
    cfg_write(0, 1);
    pulse_start();
    run_obs(1100, 10, -1, 2, 1000, fa, fb, fc, sp, ia, pt, nb, fbad);
    n_cmp++;
    if (fa != 1 || sp != 0 || ia != 1000 || nb != 0) begin
      n_bad++;
      $display("FAIL idle_cfg_clamp: first_a %0d sp %0d idle %0d bad %0d want 1/0/1000/0", fa, sp, ia, nb);
    end
  endtask

  task automatic test_stop_cancel();
    int fa, fb, fc, sp, ia, pt, nb, fbad;
    cfg_write(0, 250);
    pulse_start();
    run_obs(2600, 300, 400, 250, 1000, fa, fb, fc, sp, ia, pt, nb, fbad);
    n_cmp++;
    if (ia != -1 || sp != 0 || fc != 999 || nb != 0) begin
      n_bad++;
      $display("FAIL stop_cancel: idle %0d sp %0d first_c %0d bad %0d want -1/0/999/0", ia, sp, fc, nb);
    end
    run_obs(1100, 0, -1, 250, 1000, fa, fb, fc, sp, ia, pt, nb, fbad);
    n_cmp++;
    if (ia < 1 || ia > 1000 || pt != 0 || nb != 0) begin
      n_bad++;
      $display("FAIL stop_latency: idle %0d post %0d bad %0d want 1..1000/0/0", ia, pt, nb);
    end
  endtask

  task automatic test_cfg_running();
    int nb, fbad;
    nb = 0; fbad = -1;
    cfg_write(0, 500);
    cfg_write(1, 1000);
    cfg_write(2, 1500);
    pulse_start();
    for (int k = 0; k < 2600; k++) begin
      if (act !== exp_vec()) begin
        if (nb == 0) fbad = k;
        nb++;
      end
      if (k == 302) begin
        n_cmp++;
        if ({cfg_pending_o, cfg_ready_o} !== 2'b10) begin
          n_bad++; $display("FAIL run_cfg_pending: got %b want 10", {cfg_pending_o, cfg_ready_o});
        end
      end
      if (k == 1500) begin
        n_cmp++;
        if ({cfg_pending_o, cfg_ready_o} !== 2'b01) begin
          n_bad++; $display("FAIL run_cfg_applied: got %b want 01", {cfg_pending_o, cfg_ready_o});
        end
      end
      if (k == 1999) begin
        n_cmp++;
        if ({tick_a_o, tick_c_o} !== 2'b10) begin
          n_bad++; $display("FAIL run_realign_mid: got %b want 10", {tick_a_o, tick_c_o});
        end
      end
      if (k == 2499) begin
        n_cmp++;
        if ({tick_a_o, tick_b_o, tick_c_o} !== 3'b111) begin
          n_bad++; $display("FAIL run_realign_coinc: got %b want 111", {tick_a_o, tick_b_o, tick_c_o});
        end
      end
      cfg_valid_i = (k >= 300 && k <= 305);
      cfg_sel_i   = (k == 300) ? 2'd2 : 2'd0;
      cfg_div_i   = (k == 300) ? W'(1000) : W'(7);
      @(negedge clk);
    end
    cfg_valid_i = 1'b0;
    n_cmp++;
    if (nb != 0) begin n_bad++; $display("FAIL run_cfg_model: %0d bad cycles (first %0d) want 0", nb, fbad); end
  endtask

  task automatic test_reset_midrun();
    int fa, fb, fc, sp, ia, pt, nb, fbad;
    cfg_write(0, 100);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (act !== 6'b000001) begin n_bad++; $display("FAIL midrun_reset: got %b want 000001", act); end
    rst = 1'b1;
    @(negedge clk);
    pulse_start();
    run_obs(1100, -1, -1, 500, 31250, fa, fb, fc, sp, ia, pt, nb, fbad);
    n_cmp++;
    if (fa != 499 || fb != 999 || sp != 0 || nb != 0) begin
      n_bad++;
      $display("FAIL midrun_divs: first_a %0d first_b %0d sp %0d bad %0d want 499/999/0/0", fa, fb, sp, nb);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    int nb, fbad;
    nb = 0; fbad = -1;
    cfg_write(2, 300);
    for (int k = 0; k < 15000; k++) begin
      if (act !== exp_vec()) begin
        if (nb == 0) fbad = k;
        nb++;
      end
      rst         = (k != 12000);
      start_i     = ($urandom_range(0, 299) == 0);
      stop_i      = ($urandom_range(0, 49) == 0);
      cfg_valid_i = ($urandom_range(0, 39) == 0);
      cfg_sel_i   = 2'($urandom_range(0, 3));
      cfg_div_i   = (cfg_sel_i == 2'd2) ? W'($urandom_range(2, 400)) : W'($urandom_range(0, 300));
      @(negedge clk);
    end
    rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; cfg_valid_i = 1'b0;
    n_cmp++;
    if (nb != 0) begin n_bad++; $display("FAIL random_model: %0d bad cycles (first %0d) want 0", nb, fbad); end
  endtask

  initial begin
    test_reset();
    test_defaults_stop();
    test_cfg_idle();
    test_stop_cancel();
    test_cfg_running();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
